// File: rtl/toi2s_pkg.sv
// Shared types and constants for the toi2s amplifier init sequencer.
//   amp_seq_state_t : sequencer state encoding, also exported on state_dbg
//   NUM_WRITES      : number of amplifier register writes at power-up
//   INIT_TABLE      : {reg[15:8], data[7:0]} pairs, issued in index order
//   cnt_width()     : width of a counter that runs 0..limit-1
package toi2s_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PWRUP    = 4'd1,
    ST_WRITE    = 4'd2,
    ST_WAIT_RSP = 4'd3,
    ST_MUTED    = 4'd4,
    ST_PLAY     = 4'd5,
    ST_ERROR    = 4'd6
  } amp_seq_state_t;

  localparam int unsigned NUM_WRITES = 4;

  // Element 0 is the rightmost entry of the concatenation.
  localparam logic [NUM_WRITES-1:0][15:0] INIT_TABLE = {
    16'h04_80,
    16'h03_30,
    16'h02_03,
    16'h01_00
  };

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Loadable saturating delay counter.
//   clk, resetb : clock, asynchronous active-low reset
//   clr         : synchronous clear to zero (highest priority)
//   load        : load load_val
//   en          : count up by one, saturating at LIMIT-1
//   term        : count has reached LIMIT-1, i.e. this is the LIMIT-th
//                 consecutive enabled cycle since the last clear
module seq_delay_counter
  import toi2s_pkg::*;
#(
  parameter int unsigned LIMIT = 16,
  localparam int unsigned CW = cnt_width(LIMIT)
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          term
);

  logic [CW-1:0] count_d, count_q;

  assign term = (count_q == CW'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && !term) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/amp_init_sequencer.sv
// Power-up / configuration controller for the external class-D amplifier.
// Releases amp_nenable, waits for the amp to settle, writes INIT_TABLE over
// the I2C master command port (with NACK retries), then drives amp_mute
// from the S/PDIF decoder lock status.
//   clk, resetb          : clock, asynchronous active-low reset
//   ena                  : enable; low returns to IDLE (bus transactions
//                          in flight are completed first)
//   audio_locked         : decoder lock, synchronous to clk
//   cmd_valid/ready      : write command handshake to the I2C master
//   cmd_dev/reg/data     : command fields
//   cmd_done/cmd_nack    : transaction completion pulse and NACK status
//   amp_nenable/amp_mute : amplifier pads
//   init_done/init_err   : all writes acknowledged / retry budget exhausted
//   state_dbg            : current state encoding
// Build option: AMP_INIT_RESTART_EN adds restart_req, which re-runs the full
// sequence from MUTED, PLAY or ERROR.
module amp_init_sequencer
  import toi2s_pkg::*;
#(
  parameter int unsigned ENABLE_DLY_CYC = 1024,
  parameter int unsigned UNMUTE_DLY_CYC = 4096,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [6:0]  AMP_DEV_ADDR   = 7'h2C
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       ena,
  input  logic       audio_locked,
`ifdef AMP_INIT_RESTART_EN
  input  logic       restart_req,
`endif
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [6:0] cmd_dev,
  output logic [7:0] cmd_reg,
  output logic [7:0] cmd_data,
  input  logic       cmd_done,
  input  logic       cmd_nack,
  output logic       amp_nenable,
  output logic       amp_mute,
  output logic       init_done,
  output logic       init_err,
  output logic [3:0] state_dbg
);

  localparam int unsigned IDX_W = cnt_width(NUM_WRITES);
  localparam int unsigned RTY_W = cnt_width(MAX_RETRY);
  localparam int unsigned PWR_W = cnt_width(ENABLE_DLY_CYC);
  localparam int unsigned LCK_W = cnt_width(UNMUTE_DLY_CYC);

  amp_seq_state_t state_d, state_q;
  logic [IDX_W-1:0] index_d, index_q;
  logic [RTY_W-1:0] retry_d, retry_q;
  logic abort_d, abort_q;
  logic amp_nenable_d, amp_nenable_q;
  logic amp_mute_d, amp_mute_q;
  logic cmd_valid_d, cmd_valid_q;
  logic [7:0] cmd_reg_d, cmd_reg_q;
  logic [7:0] cmd_data_d, cmd_data_q;
  logic init_done_d, init_done_q;
  logic init_err_d, init_err_q;
  logic pwr_term, lock_term;
  logic restart;

`ifdef AMP_INIT_RESTART_EN
  assign restart = restart_req;
`else
  assign restart = 1'b0;
`endif

  seq_delay_counter #(.LIMIT(ENABLE_DLY_CYC)) u_pwr_dly (
    .clk      (clk),
    .resetb   (resetb),
    .clr      (state_q != ST_PWRUP),
    .load     (1'b0),
    .load_val (PWR_W'(0)),
    .en       (state_q == ST_PWRUP),
    .term     (pwr_term)
  );

  // Any unlocked cycle restarts the continuous-lock measurement.
  seq_delay_counter #(.LIMIT(UNMUTE_DLY_CYC)) u_lock_dly (
    .clk      (clk),
    .resetb   (resetb),
    .clr      ((state_q != ST_MUTED) || !audio_locked),
    .load     (1'b0),
    .load_val (LCK_W'(0)),
    .en       (state_q == ST_MUTED),
    .term     (lock_term)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    retry_d = retry_q;
    abort_d = abort_q;

    case (state_q)
      ST_IDLE: begin
        index_d = '0;
        retry_d = '0;
        abort_d = 1'b0;
        if (ena) state_d = ST_PWRUP;
      end
      ST_PWRUP: begin
        if (!ena)          state_d = ST_IDLE;
        else if (pwr_term) state_d = ST_WRITE;
      end
      // A disable during a bus transaction is remembered and acted on only
      // once the master reports completion.
      ST_WRITE: begin
        if (!ena) abort_d = 1'b1;
        if (cmd_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (!ena) abort_d = 1'b1;
        if (cmd_done) begin
          if (abort_q || !ena) begin
            state_d = ST_IDLE;
          end else if (!cmd_nack) begin
            retry_d = '0;
            if (index_q == IDX_W'(NUM_WRITES - 1)) begin
              state_d = ST_MUTED;
            end else begin
              index_d = index_q + 1'b1;
              state_d = ST_WRITE;
            end
          end else if ((32'(retry_q) + 32'd1) < MAX_RETRY) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_MUTED: begin
        if (!ena || restart)             state_d = ST_IDLE;
        else if (audio_locked && lock_term) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (!ena || restart)   state_d = ST_IDLE;
        else if (!audio_locked) state_d = ST_MUTED;
      end
      ST_ERROR: begin
        if (!ena || restart) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so every pad is a flop and
    // changes together with state_dbg. A restart passes through IDLE for one
    // cycle, which gives the forced mute/disable pulse.
    amp_nenable_d = (state_d == ST_IDLE) || (state_d == ST_ERROR);
    amp_mute_d    = (state_d != ST_PLAY);
    cmd_valid_d   = (state_d == ST_WRITE);
    init_done_d   = (state_d == ST_MUTED) || (state_d == ST_PLAY);
    init_err_d    = (state_d == ST_ERROR);
    cmd_reg_d     = cmd_reg_q;
    cmd_data_d    = cmd_data_q;
    if (state_d == ST_WRITE) begin
      cmd_reg_d  = INIT_TABLE[index_d][15:8];
      cmd_data_d = INIT_TABLE[index_d][7:0];
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= ST_IDLE;
      index_q       <= '0;
      retry_q       <= '0;
      abort_q       <= 1'b0;
      amp_nenable_q <= 1'b1;
      amp_mute_q    <= 1'b1;
      cmd_valid_q   <= 1'b0;
      cmd_reg_q     <= '0;
      cmd_data_q    <= '0;
      init_done_q   <= 1'b0;
      init_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      retry_q       <= retry_d;
      abort_q       <= abort_d;
      amp_nenable_q <= amp_nenable_d;
      amp_mute_q    <= amp_mute_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_reg_q     <= cmd_reg_d;
      cmd_data_q    <= cmd_data_d;
      init_done_q   <= init_done_d;
      init_err_q    <= init_err_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_dev     = AMP_DEV_ADDR;
  assign cmd_reg     = cmd_reg_q;
  assign cmd_data    = cmd_data_q;
  assign amp_nenable = amp_nenable_q;
  assign amp_mute    = amp_mute_q;
  assign init_done   = init_done_q;
  assign init_err    = init_err_q;
  assign state_dbg   = state_q;

endmodule
